cpu_run_ctrl: RTL and testbench

Run/halt/single-step sequencer for the single-cycle MIPS core. It produces one execution enable, `cpu_en`, which the top level ANDs into the PC register update, register-file `we3` and data-RAM `we`. While `cpu_en` is low the core holds its architectural state. The block also provides an instruction-retire counter, a halt-reason code and an optional PC breakpoint, all for bring-up on the board.

---
 rtl/cpu_run_ctrl.sv | 116 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle MIPS core; optional PC breakpoint under MINI_CPU_BREAKPOINT_EN.
// Latency: a request sampled at edge N changes state at N, and cpu_en follows in the next cycle.
// Backpressure: none; requests are levels, and cpu_en gates PC, register-file and data-RAM writes.
module cpu_run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic             running,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_BRK    = 2'd3
  } state_t;

  localparam logic [1:0] HR_RESET = 2'd0;
  localparam logic [1:0] HR_HALT  = 2'd1;
  localparam logic [1:0] HR_STEP  = 2'd2;
  localparam logic [1:0] HR_BP    = 2'd3;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] reason_d;
  logic       bp_hit;

`ifdef MINI_CPU_BREAKPOINT_EN
  logic bp_skip_q;

  // bp_skip lets the breakpoint instruction execute once after resuming from BRK.
  assign bp_hit = bp_valid && (pc == bp_addr) && !bp_skip_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      bp_skip_q <= 1'b0;
    end else if (cpu_en) begin
      bp_skip_q <= 1'b0;
    end else if ((state_q == S_BRK) && !halt_req && (step_req || run_req)) begin
      bp_skip_q <= 1'b1;
    end
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
`endif

  always_comb begin
    state_d  = state_q;
    reason_d = halt_reason;
    cpu_en   = 1'b0;
    case (state_q)
      S_HALTED, S_BRK: begin
        if (halt_req) begin
          state_d = state_q;
        end else if (step_req) begin
          state_d = S_STEP;
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cpu_en = !bp_hit;
        if (halt_req) begin
          state_d  = S_HALTED;
          reason_d = HR_HALT;
        end else if (bp_hit) begin
          state_d  = S_BRK;
          reason_d = HR_BP;
        end
      end
      S_STEP: begin
        cpu_en   = 1'b1;
        state_d  = S_HALTED;
        reason_d = HR_STEP;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_HALTED;
      halt_reason <= HR_RESET;
      running     <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_reason <= reason_d;
      running     <= (state_d == S_RUN) || (state_d == S_STEP);
    end
  end

  // Counter wraps silently at full scale.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_count <= '0;
    end else if (cpu_en) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a PC model advances by 4 on every cpu_en edge; expectations go through a scoreboard queue.
module tb_cpu_run_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        run_req, halt_req, step_req, bp_valid;
  logic [31:0] pc, bp_addr;
  logic        cpu_en, running;
  logic [1:0]  halt_reason;
  logic [31:0] instr_count;
  logic        cpu_en4, running4;
  logic [1:0]  halt_reason4;
  logic [3:0]  instr_count4;

  always #5 CLK = ~CLK;

  cpu_run_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(cpu_en), .running(running),
    .halt_reason(halt_reason), .instr_count(instr_count)
  );

  cpu_run_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(cpu_en4), .running(running4),
    .halt_reason(halt_reason4), .instr_count(instr_count4)
  );

  always @(posedge CLK) begin
    if (RST) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  int en_cycles = 0;
  always @(negedge CLK) begin
    if (cpu_en === 1'b1) en_cycles <= en_cycles + 1;
  end

  int total = 0;
  int bad   = 0;
  int base;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    bp_valid = 1'b0; bp_addr = 32'd0;

    // reset state
    tick();
    push("rst_en", 0); push("rst_running", 0); push("rst_reason", 0); push("rst_cnt", 0);
    pop_check(32'(cpu_en)); pop_check(32'(running)); pop_check(32'(halt_reason)); pop_check(instr_count);
    tick();
    RST = 1'b0;

    // run 1 pulse, 10 idle cycles, halt pulse -> 11 instructions
    push("run_en", 1); push("run_running", 1);
    push("rh_cnt", 11); push("rh_reason", 1); push("rh_running", 0); push("rh_en", 0); push("rh_pc", 44);
    run_req = 1'b1; tick(); run_req = 1'b0;
    pop_check(32'(cpu_en)); pop_check(32'(running));
    repeat (10) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    pop_check(instr_count); pop_check(32'(halt_reason)); pop_check(32'(running));
    pop_check(32'(cpu_en)); pop_check(pc);

    // single step
    do_reset();
    base = en_cycles;
    push("step_cnt", 1); push("step_reason", 2); push("step_pc", 4);
    push("step_en_cycles", 1); push("step_running", 0);
    step_req = 1'b1; tick(); step_req = 1'b0;
    repeat (4) tick();
    pop_check(instr_count); pop_check(32'(halt_reason)); pop_check(pc);
    pop_check(32'(en_cycles - base)); pop_check(32'(running));

    // step_req held: one step every two cycles
    push("hold_cnt", 4); push("hold_pc", 16); push("hold_reason", 2);
    step_req = 1'b1; repeat (6) tick(); step_req = 1'b0;
    tick();
    pop_check(instr_count); pop_check(pc); pop_check(32'(halt_reason));

    // all three requests together: halt wins
    push("prio_en", 0); push("prio_running", 0); push("prio_cnt", 4);
    halt_req = 1'b1; step_req = 1'b1; run_req = 1'b1; tick();
    halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
    pop_check(32'(cpu_en)); pop_check(32'(running));
    repeat (3) tick();
    pop_check(instr_count);

    // step and run together: step wins, one instruction only
    push("sr_cnt", 5); push("sr_reason", 2); push("sr_running", 0);
    step_req = 1'b1; run_req = 1'b1; tick(); step_req = 1'b0; run_req = 1'b0;
    repeat (3) tick();
    pop_check(instr_count); pop_check(32'(halt_reason)); pop_check(32'(running));

    // reset mid-run
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (3) tick();
    push("mr_en", 0); push("mr_cnt", 0); push("mr_reason", 0); push("mr_running", 0); push("mr_en2", 0);
    RST = 1'b1; tick(); RST = 1'b0;
    pop_check(32'(cpu_en)); pop_check(instr_count); pop_check(32'(halt_reason)); pop_check(32'(running));
    tick();
    pop_check(32'(cpu_en));

    // counter wrap on the 4-bit instance
    do_reset();
    push("wr_cnt4", 1); push("wr_cnt32", 17); push("wr_reason4", 1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (16) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    pop_check(32'(instr_count4)); pop_check(instr_count); pop_check(32'(halt_reason4));

    // breakpoint at 0x10, running from PC 0
    do_reset();
    bp_valid = 1'b1; bp_addr = 32'h10;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (4) tick();
`ifdef MINI_CPU_BREAKPOINT_EN
    push("bp_pc", 32'h10); push("bp_en", 0);
    pop_check(pc); pop_check(32'(cpu_en));
    push("brk_cnt", 4); push("brk_reason", 3); push("brk_running", 0); push("brk_pc", 32'h10);
    tick();
    pop_check(instr_count); pop_check(32'(halt_reason)); pop_check(32'(running)); pop_check(pc);
    push("res_en", 1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    pop_check(32'(cpu_en));
    push("res_pc", 32'h14); push("res_cnt", 5);
    tick();
    pop_check(pc); pop_check(instr_count);
    push("res_running", 1); push("res_cnt2", 8);
    repeat (3) tick();
    pop_check(32'(running)); pop_check(instr_count);
`else
    push("nb_pc", 32'h10); push("nb_en", 1);
    pop_check(pc); pop_check(32'(cpu_en));
    push("nb_pc2", 32'h14); push("nb_cnt", 5); push("nb_running", 1);
    tick();
    pop_check(pc); pop_check(instr_count); pop_check(32'(running));
`endif
    push("bp_end_reason", 1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    pop_check(32'(halt_reason));
    bp_valid = 1'b0;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
